// File: rtl/ps2_key_input.sv
`timescale 1ns/1ps
// ps2_key_input: PS/2 keyboard frame receiver that turns key make/break codes into held
//   left/right/jump levels.
// Latency: key_valid and the updated levels appear FILTER_LEN+3 clk cycles after the raw
//   stop-bit falling edge.
// Backpressure: none. The keyboard cannot be stalled, so every decoded byte is presented
//   as a one-cycle pulse.
//
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   ps2_clk, ps2_data     raw asynchronous PS/2 lines (idle high)
//   left, right, jump     held key levels for the world block
//   scan_code, key_valid  last valid byte and its one-cycle strobe
//   frame_err             one-cycle pulse on a start, parity, stop or timeout error
//
// Optional feature macro: KEY_WASD_EN adds the letter keys A/D/W as second sources for
// left/right/jump.
module ps2_key_input #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 100000,
  parameter int TO_W       = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       left,
  output logic       right,
  output logic       jump,
  output logic [7:0] scan_code,
  output logic       key_valid,
  output logic       frame_err
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t state, state_nxt;

  logic                  clk_s1, clk_s2, dat_s1, dat_s2;
  logic [FILTER_LEN-1:0] filt_shift, filt_next;
  logic                  filt_clk, filt_prev, fall;

  logic [2:0]      bitcnt, bitcnt_nxt;
  logic [7:0]      shreg, shreg_nxt;
  logic            par_bit, par_nxt;
  logic [TO_W-1:0] to_cnt;
  logic            timeout_hit;
  logic            frame_ok, frame_bad;

  logic       brk, ext;
  // Hold bits are ordered {jump, right, left}. Source A holds the arrow keys and space.
  logic [2:0] hold_a, map_a;
`ifdef KEY_WASD_EN
  logic [2:0] hold_b, map_b;
`endif

  // The filter looks at the incoming sample together with the stored history. The filtered
  // level therefore flips on the same edge that completes FILTER_LEN equal samples.
  assign filt_next = {filt_shift[FILTER_LEN-2:0], clk_s2};
  assign fall      = filt_prev & ~filt_clk;

  // A real falling edge wins over an expiring timeout in the same cycle.
  assign timeout_hit = (state != IDLE) && !fall && (to_cnt == TO_W'(TIMEOUT - 1));

  // Frame FSM: next-state logic and end-of-frame classification.
  always_comb begin
    state_nxt  = state;
    bitcnt_nxt = bitcnt;
    shreg_nxt  = shreg;
    par_nxt    = par_bit;
    frame_ok   = 1'b0;
    frame_bad  = 1'b0;
    if (timeout_hit) begin
      state_nxt = IDLE;
      frame_bad = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE: begin
          if (!dat_s2) begin
            state_nxt  = DATA;
            bitcnt_nxt = 3'd0;
          end else begin
            frame_bad = 1'b1;
          end
        end
        DATA: begin
          shreg_nxt  = {dat_s2, shreg[7:1]};
          bitcnt_nxt = bitcnt + 3'd1;
          if (bitcnt == 3'd7) state_nxt = PARITY;
        end
        PARITY: begin
          par_nxt   = dat_s2;
          state_nxt = STOP;
        end
        STOP: begin
          state_nxt = IDLE;
          if (dat_s2 && (^{shreg, par_bit})) frame_ok  = 1'b1;
          else                               frame_bad = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Key map for the completed byte, qualified by the extended prefix.
  always_comb begin
    map_a = 3'b000;
`ifdef KEY_WASD_EN
    map_b = 3'b000;
`endif
    if (ext) begin
      case (shreg)
        8'h6B:   map_a = 3'b001;
        8'h74:   map_a = 3'b010;
        8'h75:   map_a = 3'b100;
        default: map_a = 3'b000;
      endcase
    end else begin
      case (shreg)
        8'h29:   map_a = 3'b100;
`ifdef KEY_WASD_EN
        8'h1C:   map_b = 3'b001;
        8'h23:   map_b = 3'b010;
        8'h1D:   map_b = 3'b100;
`endif
        default: map_a = 3'b000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1     <= 1'b1;
      clk_s2     <= 1'b1;
      dat_s1     <= 1'b1;
      dat_s2     <= 1'b1;
      filt_shift <= '1;
      filt_clk   <= 1'b1;
      filt_prev  <= 1'b1;
      state      <= IDLE;
      bitcnt     <= 3'd0;
      shreg      <= 8'h00;
      par_bit    <= 1'b0;
      to_cnt     <= '0;
      key_valid  <= 1'b0;
      frame_err  <= 1'b0;
      scan_code  <= 8'h00;
      brk        <= 1'b0;
      ext        <= 1'b0;
      hold_a     <= 3'b000;
`ifdef KEY_WASD_EN
      hold_b     <= 3'b000;
`endif
    end else begin
      clk_s1     <= ps2_clk;
      clk_s2     <= clk_s1;
      dat_s1     <= ps2_data;
      dat_s2     <= dat_s1;
      filt_shift <= filt_next;
      if (&filt_next)       filt_clk <= 1'b1;
      else if (~|filt_next) filt_clk <= 1'b0;
      filt_prev  <= filt_clk;

      state   <= state_nxt;
      bitcnt  <= bitcnt_nxt;
      shreg   <= shreg_nxt;
      par_bit <= par_nxt;

      if (fall || timeout_hit || state == IDLE) to_cnt <= '0;
      else                                      to_cnt <= to_cnt + TO_W'(1);

      key_valid <= frame_ok;
      frame_err <= frame_bad;

      // A timed-out frame may have split a prefix from its code, so the pending
      // prefixes are dropped. The held levels are left alone.
      if (timeout_hit) begin
        brk <= 1'b0;
        ext <= 1'b0;
      end

      if (frame_ok) begin
        scan_code <= shreg;
        if (shreg == 8'hE0) begin
          ext <= 1'b1;
        end else if (shreg == 8'hF0) begin
          brk <= 1'b1;
        end else begin
          hold_a <= (hold_a & ~map_a) | (brk ? 3'b000 : map_a);
`ifdef KEY_WASD_EN
          hold_b <= (hold_b & ~map_b) | (brk ? 3'b000 : map_b);
`endif
          brk <= 1'b0;
          ext <= 1'b0;
        end
      end
    end
  end

`ifdef KEY_WASD_EN
  // Each game control is held while either its arrow/space source or its letter source is held.
  assign {jump, right, left} = hold_a | hold_b;
`else
  assign {jump, right, left} = hold_a;
`endif

endmodule

// File: tb/tb_ps2_key_input.sv
`timescale 1ns/1ps
// tb_ps2_key_input: randomized PS/2 frame stimulus with a queue-based scoreboard.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_ps2_key_input;

  localparam int FL   = 8;
  localparam int TO   = 2000;
  localparam int TOW  = 11;
  localparam int HALF = 15;
  localparam int GAP  = 30;

  logic       clk, rst, ps2_clk, ps2_data;
  logic       left, right, jump, key_valid, frame_err;
  logic [7:0] scan_code;

  ps2_key_input #(.FILTER_LEN(FL), .TIMEOUT(TO), .TO_W(TOW)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .left(left), .right(right), .jump(jump),
    .scan_code(scan_code), .key_valid(key_valid), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit         is_err;
    logic [7:0] sc;
    logic [2:0] lrj;
    int         edge_cyc;
  } exp_t;
  exp_t q[$];

  // Reference model: pending prefixes plus one hold bit per key source ({jump,right,left}).
  bit         m_brk, m_ext;
  bit   [2:0] m_arrow, m_letter;
  logic [7:0] m_sc;

  function automatic logic [2:0] m_out();
    return m_arrow | m_letter;
  endfunction

  task automatic model_reset();
    m_brk = 0; m_ext = 0; m_arrow = 0; m_letter = 0; m_sc = 8'h00;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int  idx;
    bit  letter;
    idx = -1;
    letter = 0;
    m_sc = b;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (m_ext) begin
        if (b == 8'h6B) idx = 0;
        if (b == 8'h74) idx = 1;
        if (b == 8'h75) idx = 2;
      end else begin
        if (b == 8'h29) idx = 2;
`ifdef KEY_WASD_EN
        if (b == 8'h1C) begin idx = 0; letter = 1; end
        if (b == 8'h23) begin idx = 1; letter = 1; end
        if (b == 8'h1D) begin idx = 2; letter = 1; end
`endif
      end
      if (idx >= 0) begin
        if (letter) m_letter[idx] = !m_brk;
        else        m_arrow[idx]  = !m_brk;
      end
      m_brk = 0;
      m_ext = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input bit is_err, input int ec);
    exp_t e;
    e.is_err = is_err;
    e.sc = m_sc;
    e.lrj = m_out();
    e.edge_cyc = ec;
    q.push_back(e);
  endtask

  task automatic drive_bit(input bit v);
    ps2_data = v;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    logic [10:0] bits;
    int ec;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_data = bits[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      ec = cyc;
      if (i == 10) begin
        if (!bad_par) model_byte(b);
        push_exp(bad_par, ec);
      end
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_cyc(GAP);
  endtask

  task automatic chk_outs(input string tag, input logic [2:0] lrj, input logic [7:0] sc);
    chk({tag, "_lrj"}, {29'd0, jump, right, left}, {29'd0, lrj});
    chk({tag, "_scan"}, {24'd0, scan_code}, {24'd0, sc});
  endtask

  // Scoreboard monitor: every output pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && (key_valid || frame_err)) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event kv=%0b err=%0b scan=%h (t=%0t)", key_valid, frame_err, scan_code, $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("event_kind", {30'd0, key_valid, frame_err}, e.is_err ? 32'd1 : 32'd2);
        chk("event_scan", {24'd0, scan_code}, {24'd0, e.sc});
        chk("event_lrj", {29'd0, jump, right, left}, {29'd0, e.lrj});
        if (e.edge_cyc >= 0 && (cyc - e.edge_cyc) > FL + 3)
          chk("event_latency", cyc - e.edge_cyc, FL + 3);
        else if (e.edge_cyc >= 0)
          checks++;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  logic [7:0] pool [11] = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h75, 8'h29,
                            8'h1C, 8'h23, 8'h1D, 8'h12, 8'h5A};

  initial begin
    model_reset();
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    wait_cyc(5);
    chk_outs("reset", 3'b000, 8'h00);
    chk("reset_kv", {31'd0, key_valid}, 0);
    chk("reset_err", {31'd0, frame_err}, 0);
    rst = 1'b0;

    // Idle lines, then a glitch shorter than the filter: no events expected.
    wait_cyc(1000);
    chk_outs("idle", 3'b000, 8'h00);
    ps2_clk = 1'b0; wait_cyc(4); ps2_clk = 1'b1;
    wait_cyc(50);

    // Extended left make then break.
    send_frame(8'hE0, 0); send_frame(8'h6B, 0);
    chk_outs("left_make", 3'b001, 8'h6B);
    send_frame(8'hE0, 0); send_frame(8'hF0, 0); send_frame(8'h6B, 0);
    chk_outs("left_break", 3'b000, 8'h6B);

    // Space, then a parity-corrupted space.
    send_frame(8'h29, 0);
    chk_outs("jump_make", 3'b100, 8'h29);
    send_frame(8'h29, 1);
    chk_outs("bad_parity", 3'b100, 8'h29);

    // Stray falling edge with data high in IDLE.
    ps2_data = 1'b1; wait_cyc(HALF); ps2_clk = 1'b0;
    push_exp(1, cyc);
    wait_cyc(HALF); ps2_clk = 1'b1; wait_cyc(GAP);

    // Partial frame then silence: timeout.
    drive_bit(0);
    for (int i = 0; i < 4; i++) drive_bit(i[0]);
    ps2_data = 1'b1;
    m_brk = 0; m_ext = 0;
    push_exp(1, -1);
    wait_cyc(TO + 100);
    chk("timeout_drained", q.size(), 0);
    send_frame(8'hE0, 0); send_frame(8'h74, 0);
    chk_outs("right_after_to", 3'b110, 8'h74);

    // Left and right held together, then reset mid-frame.
    send_frame(8'hE0, 0); send_frame(8'h6B, 0);
    chk_outs("left_right", 3'b111, 8'h6B);
    drive_bit(0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    ps2_data = 1'b0; wait_cyc(HALF); ps2_clk = 1'b0;
    wait_cyc(3);
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    @(posedge clk); #1;
    chk_outs("mid_reset", 3'b000, 8'h00);
    chk("mid_reset_kv", {31'd0, key_valid | frame_err}, 0);
    wait_cyc(5);
    rst = 1'b0;
    model_reset();
    wait_cyc(200);

`ifdef KEY_WASD_EN
    send_frame(8'h1C, 0); send_frame(8'hE0, 0); send_frame(8'h6B, 0);
    send_frame(8'hF0, 0); send_frame(8'h1C, 0);
    chk_outs("wasd_one_src", 3'b001, 8'h1C);
    send_frame(8'hE0, 0); send_frame(8'hF0, 0); send_frame(8'h6B, 0);
    chk_outs("wasd_released", 3'b000, 8'h6B);
`else
    send_frame(8'h1C, 0);
    chk_outs("letter_unmapped", 3'b000, 8'h1C);
    send_frame(8'h6B, 0);
    chk_outs("keypad_unmapped", 3'b000, 8'h6B);
`endif

    // Randomized frames drawn from mapped, prefix and unmapped codes.
    for (int n = 0; n < 60; n++) begin
      send_frame(pool[$urandom_range(0, 10)], $urandom_range(0, 7) == 0);
    end
    chk_outs("random_end", m_out(), m_sc);

    wait_cyc(50);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
